// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the memory stage (master)
// and the data-memory responder (slave).
//
// Handshake: the master raises memenM with memwriteM/byteenM/aluoutM/
// writedataM and holds all of them stable for as long as stallM=1. The first
// cycle in which stallM=0 with memenM=1 held is the completion cycle: load
// data is valid on readdataM then, and the master may advance. adrerrM is a
// one-cycle flag aligned with that completion cycle.
interface dmem_if;
    logic        memenM;
    logic        memwriteM;
    logic [3:0]  byteenM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        adrerrM;

    modport master (
        output memenM, memwriteM, byteenM, aluoutM, writedataM,
        input  readdataM, stallM, adrerrM
    );

    modport slave (
        input  memenM, memwriteM, byteenM, aluoutM, writedataM,
        output readdataM, stallM, adrerrM
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with programmable wait states.
// An accepted request stalls the initiator for WAIT_CYCLES+1 cycles, the
// access happens on the edge into DONE, and DONE is one non-stalled cycle.
// Optional feature: define DMEM_ALIGN_CHECK_EN to suppress misaligned
// accesses and flag them on adrerrM; otherwise the low address bits are ignored.
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    dmem_if.slave      bus,
    output logic [1:0] dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [3:0]  count, count_next;
    logic        stall;
    logic        do_access;
    logic        access_en;
    logic        misaligned;
    logic [AW-1:0] word_idx;
    logic [31:0] readdata;
    logic        adrerr;
    logic [31:0] mem [DEPTH];

    assign word_idx  = bus.aluoutM[AW+1:2];
    assign access_en = do_access && !rst;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = |bus.aluoutM[1:0];
    logic unused_addr;
    assign unused_addr = ^bus.aluoutM[31:AW+2];
`else
    assign misaligned = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{bus.aluoutM[31:AW+2], bus.aluoutM[1:0]};
`endif

    // State and wait-counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next state, wait counting and stall. The acceptance cycle in IDLE is
    // the first stalled cycle, so BUSY spends exactly WAIT_CYCLES cycles:
    // the counter holds the wait states still to go including the current
    // one, and the access fires when the last one is reached. With zero
    // wait states the access fires straight from IDLE.
    always_comb begin
        state_next = state;
        count_next = count;
        do_access  = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.memenM) begin
                    stall = 1'b1;
                    if (WAIT_LD == 4'd0) begin
                        do_access  = 1'b1;
                        state_next = DONE;
                    end else begin
                        count_next = WAIT_LD;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (count > 4'd1) begin
                    count_next = count - 4'd1;
                end else begin
                    count_next = 4'd0;
                    do_access  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // memenM is still the served request here; never re-accept it.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte-masked array write; the array has no reset and keeps its contents.
    always_ff @(posedge clk) begin
        if (access_en && bus.memwriteM && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.byteenM[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.writedataM[8*i +: 8];
                end
            end
        end
    end

    // Load data and misalignment flag, both updated on the access edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readdata <= 32'h0;
            adrerr   <= 1'b0;
        end else begin
            adrerr <= access_en && misaligned;
            if (access_en && !bus.memwriteM) begin
                readdata <= misaligned ? 32'h0 : mem[word_idx];
            end
        end
    end

    assign bus.stallM    = stall;
    assign bus.readdataM = readdata;
    assign bus.adrerrM   = adrerr;
    assign dbg_state     = state;
endmodule
